// File: rtl/variable_latency_bank_adapter_if.sv
// rtl/variable_latency_bank_adapter_if.sv - request, response and SRAM signal bundle for the bank adapter
interface variable_latency_bank_adapter_if #(
    parameter int NumIn        = 32,
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8
);
    localparam int IniW = $clog2(NumIn);

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [IniW-1:0]         req_ini_addr_i;
    logic [AddrMemWidth-1:0] req_tgt_addr_i;
    logic                    req_wen_i;
    logic [DataWidth-1:0]    req_wdata_i;
    logic [BeWidth-1:0]      req_be_i;
    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [IniW-1:0]         resp_ini_addr_o;
    logic [DataWidth-1:0]    resp_rdata_o;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [AddrMemWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0]    mem_wdata_o;
    logic [BeWidth-1:0]      mem_be_o;
    logic [DataWidth-1:0]    mem_rdata_i;

    modport slave (
        input  req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
        input  resp_ready_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_valid_i, req_ini_addr_i, req_tgt_addr_i, req_wen_i, req_wdata_i, req_be_i,
        output resp_ready_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/variable_latency_bank_adapter.sv
// rtl/variable_latency_bank_adapter.sv - valid/ready requests to fixed-latency SRAM with credit-protected tagged read responses
module variable_latency_bank_adapter #(
    parameter int NumIn         = 32,
    parameter int AddrMemWidth  = 12,
    parameter int DataWidth     = 32,
    parameter int BeWidth       = DataWidth / 8,
    parameter int MemLatency    = 1,
    parameter int RespFifoDepth = 2
) (
    input logic                            clk_i,
    input logic                            rst_i,
    variable_latency_bank_adapter_if.slave bus
);
    localparam int IniW  = $clog2(NumIn);
    localparam int PtrW  = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
    localparam int FCntW = $clog2(RespFifoDepth + 1);
    localparam int OutW  = $clog2(RespFifoDepth + MemLatency + 1);

    logic                  rst_q;
    logic                  fire;
    logic [MemLatency-1:0] pipe_valid_q, pipe_valid_d;
    logic [IniW-1:0]       pipe_tag_q [MemLatency];
    logic [IniW-1:0]       pipe_tag_d [MemLatency];
    logic [IniW-1:0]       fifo_tag_q [RespFifoDepth];
    logic [DataWidth-1:0]  fifo_data_q [RespFifoDepth];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCntW-1:0]      count_q, count_d;
    logic [OutW-1:0]       outstanding;
    logic                  push, fifo_empty, pop_fifo, bypass, store;

    // Outstanding reads = entries waiting in the FIFO plus reads still inside the SRAM pipeline
    always_comb begin
        outstanding = OutW'(count_q);
        for (int k = 0; k < MemLatency; k++) begin
            outstanding = outstanding + OutW'(pipe_valid_q[k]);
        end
    end

    assign bus.req_ready_o = ~rst_i & ~rst_q & (outstanding < OutW'(RespFifoDepth));
    assign fire            = bus.req_valid_i & bus.req_ready_o;

    assign bus.mem_req_o   = fire;
    assign bus.mem_we_o    = fire & bus.req_wen_i;
    assign bus.mem_addr_o  = fire ? bus.req_tgt_addr_i : '0;
    assign bus.mem_wdata_o = fire ? bus.req_wdata_i : '0;
    assign bus.mem_be_o    = fire ? bus.req_be_i : '0;

    // Tag pipeline tracks each read until its SRAM data appears on mem_rdata_i
    always_comb begin
        pipe_valid_d    = '0;
        pipe_valid_d[0] = fire & ~bus.req_wen_i;
        pipe_tag_d[0]   = bus.req_ini_addr_i;
        for (int k = 1; k < MemLatency; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_tag_d[k]   = pipe_tag_q[k-1];
        end
    end

    assign push       = pipe_valid_q[MemLatency-1];
    assign fifo_empty = (count_q == '0);
    assign pop_fifo   = ~rst_i & ~fifo_empty & bus.resp_ready_i;
    assign bypass     = fifo_empty & push & bus.resp_ready_i;
    assign store      = push & ~bypass;

    // FIFO pointer and occupancy bookkeeping; pointers wrap at the depth, not at a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + FCntW'(store) - FCntW'(pop_fifo);
        if (store) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(RespFifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_fifo) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(RespFifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Response mux: FIFO head has priority so ordering holds; otherwise the arriving read falls through
    always_comb begin
        bus.resp_valid_o    = ~rst_i & (~fifo_empty | push);
        bus.resp_ini_addr_o = '0;
        bus.resp_rdata_o    = '0;
        if (!rst_i) begin
            if (!fifo_empty) begin
                bus.resp_ini_addr_o = fifo_tag_q[rd_ptr_q];
                bus.resp_rdata_o    = fifo_data_q[rd_ptr_q];
            end else if (push) begin
                bus.resp_ini_addr_o = pipe_tag_q[MemLatency-1];
                bus.resp_rdata_o    = bus.mem_rdata_i;
            end
        end
    end

    // Control state; reset discards any read still in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_q        <= 1'b1;
            pipe_valid_q <= '0;
            for (int k = 0; k < MemLatency; k++) begin
                pipe_tag_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rst_q        <= 1'b0;
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage is only read when occupancy says the slot is live, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (store) begin
            fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[MemLatency-1];
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata_i;
        end
    end

    // Parameter sanity and the no-overflow guarantee the credit scheme provides
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (MemLatency >= 1) else $error("MemLatency must be at least 1");
            assert (RespFifoDepth >= MemLatency) else $error("RespFifoDepth below MemLatency");
            assert (!(store && (count_q == FCntW'(RespFifoDepth)))) else $error("push into full response FIFO");
        end
    end
endmodule

// File: tb/tb_variable_latency_bank_adapter.sv
// tb/tb_variable_latency_bank_adapter.sv - directed and randomized self-checking bench for the bank adapter
module tb_variable_latency_bank_adapter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    variable_latency_bank_adapter_if #(.NumIn(32), .AddrMemWidth(12), .DataWidth(32)) b1 ();
    variable_latency_bank_adapter_if #(.NumIn(32), .AddrMemWidth(12), .DataWidth(32)) b2 ();

    variable_latency_bank_adapter #(.MemLatency(1), .RespFifoDepth(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave)
    );
    variable_latency_bank_adapter #(.MemLatency(2), .RespFifoDepth(3)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];
    logic [31:0] rd1, rd2a, rd2b;
    logic [31:0] gold [16];

    // SRAM models: one-cycle and two-cycle read latency with byte-enabled writes
    always @(posedge clk) begin
        if (b1.mem_req_o) begin
            if (b1.mem_we_o) begin
                for (int j = 0; j < 4; j++)
                    if (b1.mem_be_o[j]) mem1[b1.mem_addr_o][8*j +: 8] <= b1.mem_wdata_o[8*j +: 8];
            end else begin
                rd1 <= mem1[b1.mem_addr_o];
            end
        end
    end
    always @(posedge clk) begin
        if (b2.mem_req_o && !b2.mem_we_o) rd2a <= mem2[b2.mem_addr_o];
        rd2b <= rd2a;
    end
    assign b1.mem_rdata_i = rd1;
    assign b2.mem_rdata_i = rd2b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          acc, issued, exp_tag, nresp, last_c, done, outst, max_out;
    logic        fired, hv;
    logic [4:0]  htag, rtag;
    logic [31:0] hdata, wd;
    logic [3:0]  rbe;
    logic [3:0]  radr;
    logic [36:0] expq[$];
    logic [36:0] e;

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 4096; i++) begin
            mem1[i] <= 32'h0;
            mem2[i] <= 32'h0;
        end
        #0;
        mem1[12'h010] <= 32'hDEADBEEF;
        mem1[12'h020] <= 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) mem1[12'h100 + i] <= 32'h1000_0000 + i;
        for (int i = 0; i < 16; i++) begin
            mem1[12'h300 + i] <= 32'h3000_0000 + i;
            gold[i] = 32'h3000_0000 + i;
            mem2[12'h200 + i] <= 32'h2000_0000 + i;
        end

        rst = 1'b1;
        b1.req_valid_i = 1'b1; b1.req_ini_addr_i = '0; b1.req_tgt_addr_i = '0; b1.req_wen_i = 1'b0;
        b1.req_wdata_i = '0; b1.req_be_i = 4'hF; b1.resp_ready_i = 1'b0;
        b2.req_valid_i = 1'b1; b2.req_ini_addr_i = '0; b2.req_tgt_addr_i = '0; b2.req_wen_i = 1'b0;
        b2.req_wdata_i = '0; b2.req_be_i = 4'hF; b2.resp_ready_i = 1'b0;

        // reset held three cycles with requests pending
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready1", b1.req_ready_o, 0);
            check("rst_resp1", b1.resp_valid_o, 0);
            check("rst_memreq1", b1.mem_req_o, 0);
            check("rst_ready2", b2.req_ready_o, 0);
        end
        rst = 1'b0; b1.req_valid_i = 1'b0; b2.req_valid_i = 1'b0;
        #1 check("rel_ready_same_cycle", b1.req_ready_o, 0);
        tick();
        check("rel_ready1", b1.req_ready_o, 1);
        check("rel_ready2", b2.req_ready_o, 1);
        check("rel_memrdata_ignored", b1.resp_valid_o, 0);

        // single read, tag 5 at 0x010
        b1.req_valid_i = 1'b1; b1.req_tgt_addr_i = 12'h010; b1.req_ini_addr_i = 5'd5; b1.resp_ready_i = 1'b1;
        #1;
        check("rd_memreq", b1.mem_req_o, 1);
        check("rd_memwe", b1.mem_we_o, 0);
        check("rd_memaddr", b1.mem_addr_o, 12'h010);
        tick();
        b1.req_valid_i = 1'b0;
        #1;
        check("rd_resp_valid", b1.resp_valid_o, 1);
        check("rd_resp_tag", b1.resp_ini_addr_o, 5);
        check("rd_resp_data", b1.resp_rdata_o, 32'hDEADBEEF);
        tick();
        check("rd_resp_gone", b1.resp_valid_o, 0);

        // partial write, then readback of merged bytes
        b1.req_valid_i = 1'b1; b1.req_wen_i = 1'b1; b1.req_tgt_addr_i = 12'h020;
        b1.req_be_i = 4'b0011; b1.req_wdata_i = 32'h12345678;
        #1;
        check("wr_memreq", b1.mem_req_o, 1);
        check("wr_memwe", b1.mem_we_o, 1);
        check("wr_membe", b1.mem_be_o, 4'b0011);
        check("wr_memwdata", b1.mem_wdata_o, 32'h12345678);
        tick();
        b1.req_valid_i = 1'b0; b1.req_wen_i = 1'b0; b1.req_be_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 check("wr_no_resp", b1.resp_valid_o, 0);
            tick();
        end
        b1.req_valid_i = 1'b1; b1.req_tgt_addr_i = 12'h020; b1.req_ini_addr_i = 5'd3;
        #1 check("rb_ready", b1.req_ready_o, 1);
        tick();
        b1.req_valid_i = 1'b0;
        #1;
        check("rb_valid", b1.resp_valid_o, 1);
        check("rb_tag", b1.resp_ini_addr_o, 3);
        check("rb_data", b1.resp_rdata_o, 32'hCAFE5678);
        tick();

        // backpressure: four back-to-back reads against a stalled response port
        b1.resp_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            b1.req_valid_i = (acc < 4);
            b1.req_ini_addr_i = 5'(acc + 1);
            b1.req_tgt_addr_i = 12'(12'h100 + acc);
            #1 fired = b1.req_valid_i & b1.req_ready_o;
            tick();
            if (fired) acc++;
        end
        check("bp_accepted", acc, 2);
        check("bp_ready_low", b1.req_ready_o, 0);
        check("bp_hold_valid", b1.resp_valid_o, 1);
        check("bp_hold_tag", b1.resp_ini_addr_o, 1);
        check("bp_hold_data", b1.resp_rdata_o, 32'h1000_0000);
        b1.resp_ready_i = 1'b1;
        #1 check("bp_ready_pop_cycle", b1.req_ready_o, 0);
        tick();
        check("bp_ready_after_pop", b1.req_ready_o, 1);
        exp_tag = 2; issued = 2;
        for (int c = 0; c < 20 && exp_tag <= 4; c++) begin
            b1.req_valid_i = (issued < 4);
            b1.req_ini_addr_i = 5'(issued + 1);
            b1.req_tgt_addr_i = 12'(12'h100 + issued);
            #1;
            if (b1.resp_valid_o) begin
                check("bp_order_tag", b1.resp_ini_addr_o, 64'(exp_tag));
                check("bp_order_data", b1.resp_rdata_o, 64'(32'h1000_0000 + exp_tag - 1));
                exp_tag++;
            end
            if (b1.req_valid_i && b1.req_ready_o) issued++;
            tick();
        end
        b1.req_valid_i = 1'b0;
        check("bp_all_returned", exp_tag, 5);

        // throughput on the two-cycle SRAM instance
        b2.resp_ready_i = 1'b1;
        issued = 0; nresp = 0; last_c = -1;
        for (int c = 0; c < 25; c++) begin
            b2.req_valid_i = (issued < 16);
            b2.req_ini_addr_i = 5'(issued);
            b2.req_tgt_addr_i = 12'(12'h200 + issued);
            #1;
            if (c < 16) check("tp_ready", b2.req_ready_o, 1);
            if (b2.resp_valid_o) begin
                check("tp_tag", b2.resp_ini_addr_o, 64'(nresp));
                check("tp_data", b2.resp_rdata_o, 64'(32'h2000_0000 + nresp));
                nresp++;
                last_c = c;
            end
            if (b2.req_valid_i && b2.req_ready_o) issued++;
            tick();
        end
        b2.req_valid_i = 1'b0;
        check("tp_count", nresp, 16);
        check("tp_last_cycle", last_c, 17);

        // random mix against a golden memory
        done = 0; outst = 0; max_out = 0; hv = 1'b0;
        for (int c = 0; c < 80000 && (done < 10000 || expq.size() > 0); c++) begin
            if (!b1.req_valid_i && done < 10000) begin
                radr = 4'($urandom_range(0, 15));
                rtag = 5'($urandom_range(0, 31));
                wd   = $urandom;
                rbe  = 4'($urandom_range(0, 15));
                b1.req_valid_i = 1'b1;
                b1.req_wen_i = ($urandom_range(0, 1) == 1);
                b1.req_tgt_addr_i = {8'h30, radr};
                b1.req_ini_addr_i = rtag;
                b1.req_wdata_i = wd;
                b1.req_be_i = rbe;
            end
            b1.resp_ready_i = ($urandom_range(0, 99) < 30);
            #1;
            if (hv) begin
                check("rand_hold_valid", b1.resp_valid_o, 1);
                check("rand_hold_tag", b1.resp_ini_addr_o, htag);
                check("rand_hold_data", b1.resp_rdata_o, hdata);
            end
            hv = b1.resp_valid_o & ~b1.resp_ready_i;
            htag = b1.resp_ini_addr_o;
            hdata = b1.resp_rdata_o;
            if (b1.resp_valid_o && b1.resp_ready_i) begin
                if (expq.size() == 0) begin
                    check("rand_spurious_resp", b1.resp_valid_o, 0);
                end else begin
                    e = expq.pop_front();
                    check("rand_tag", b1.resp_ini_addr_o, e[36:32]);
                    check("rand_data", b1.resp_rdata_o, e[31:0]);
                    outst--;
                end
            end
            fired = b1.req_valid_i & b1.req_ready_o;
            if (fired) begin
                if (b1.req_wen_i) begin
                    for (int j = 0; j < 4; j++)
                        if (b1.req_be_i[j]) gold[b1.req_tgt_addr_i[3:0]][8*j +: 8] = b1.req_wdata_i[8*j +: 8];
                end else begin
                    expq.push_back({b1.req_ini_addr_i, gold[b1.req_tgt_addr_i[3:0]]});
                    outst++;
                end
                done++;
            end
            if (outst > max_out) max_out = outst;
            tick();
            if (fired) b1.req_valid_i = 1'b0;
        end
        b1.req_valid_i = 1'b0;
        check("rand_all_issued", done, 10000);
        check("rand_no_drops", expq.size(), 0);
        check("rand_max_outstanding_ok", (max_out <= 2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
